// File: rtl/fib2mac_txctrl.sv
// fib2mac_txctrl: read side of the AXIS-to-MAC TX path.
// Pops a frame byte count from the TX wbcnt FIFO, then the matching number of
// 64-bit words from the TX data FIFO. Presents them to the LMAC TX core as a
// sop/eop/mod framed stream through a 2-entry skid buffer under mac_tx_ready.
// Optional build macro FIB2MAC_STATS_EN adds stat_frames/stat_bytes counters
// and a synchronous stat_clr input.
module fib2mac_txctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int BCNT_WIDTH = 32,
  parameter int MAX_BCNT   = 9600
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  txwbcnt_rdreq,
  input  logic [BCNT_WIDTH-1:0] rd_txwbcnt_fifo,
  input  logic                  txwbcnt_rdempty,
  output logic                  txdata_rdreq,
  input  logic [DATA_WIDTH-1:0] rd_txdata_fifo,
  input  logic                  txdata_rdempty,
  output logic [DATA_WIDTH-1:0] mac_tx_data,
  output logic                  mac_tx_valid,
  output logic                  mac_tx_sop,
  output logic                  mac_tx_eop,
  output logic [2:0]            mac_tx_mod,
  input  logic                  mac_tx_ready,
  output logic                  frame_err,
  output logic                  test
`ifdef FIB2MAC_STATS_EN
  ,
  output logic [31:0]           stat_frames,
  output logic [31:0]           stat_bytes,
  input  logic                  stat_clr
`endif
);

  localparam int WL_W = BCNT_WIDTH - 2;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_LEN  = 4'b0010,
    S_DATA = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [2:0]            mod;
  } beat_t;

  state_t          state_q, state_d;
  logic [WL_W-1:0] words_left_q, words_left_d;
  logic [WL_W-1:0] words_calc;
  logic            drop_q, drop_d;
  logic            first_q, first_d;
  logic [2:0]      mod_q;
  logic            len_load;
  logic            wb_rd;
  logic            data_rd;
  logic            err;

  // Read issued last cycle; its data is on rd_txdata_fifo this cycle.
  logic            inflight_q;
  logic            infl_sop_q;
  logic            infl_eop_q;

  // Skid buffer: head_q drives the MAC, tail_q holds the second entry.
  beat_t           head_q, tail_q;
  beat_t           new_beat;
  logic [1:0]      cnt_q;
  logic            push;
  logic            pop;
  logic [2:0]      occ;

  assign len_load   = (state_q == S_LEN);
  assign words_calc = WL_W'(rd_txwbcnt_fifo >> 3) + WL_W'(|rd_txwbcnt_fifo[2:0]);

  assign pop  = (cnt_q != 2'd0) && mac_tx_ready;
  assign push = inflight_q && !drop_q;
  // Slots committed after this edge: held entries plus returning word, minus a departing one.
  assign occ  = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);

  assign data_rd = !reset && (state_q == S_DATA) && (words_left_q != '0) &&
                   !txdata_rdempty && (occ < 3'd2);

  always_comb begin
    new_beat.data = rd_txdata_fifo;
    new_beat.sop  = infl_sop_q;
    new_beat.eop  = infl_eop_q;
    new_beat.mod  = infl_eop_q ? mod_q : 3'd0;
  end

  // Next-state and control decode for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    drop_d       = drop_q;
    first_d      = first_q;
    wb_rd        = 1'b0;
    err          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!txwbcnt_rdempty) begin
          wb_rd   = 1'b1;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rd_txwbcnt_fifo == '0) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          // Oversized frames are still read out word by word so both FIFOs stay aligned.
          err          = (rd_txwbcnt_fifo > BCNT_WIDTH'(MAX_BCNT));
          drop_d       = err;
          words_left_d = words_calc;
          first_d      = 1'b1;
          state_d      = S_DATA;
        end
      end
      S_DATA: begin
        if (data_rd) begin
          words_left_d = words_left_q - WL_W'(1);
          first_d      = 1'b0;
        end
        if ((words_left_q == '0) && !inflight_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (cnt_q == 2'd0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, word counter and in-flight read tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      words_left_q <= '0;
      drop_q       <= 1'b0;
      first_q      <= 1'b0;
      mod_q        <= '0;
      inflight_q   <= 1'b0;
      infl_sop_q   <= 1'b0;
      infl_eop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      drop_q       <= drop_d;
      first_q      <= first_d;
      if (len_load) begin
        mod_q <= rd_txwbcnt_fifo[2:0];
      end
      inflight_q   <= data_rd;
      infl_sop_q   <= data_rd && first_q;
      infl_eop_q   <= data_rd && (words_left_q == WL_W'(1));
    end
  end

  // Two-entry skid buffer; head always holds the oldest beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= new_beat;
          else               tail_q <= new_beat;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= new_beat;
          end else begin
            head_q <= tail_q;
            tail_q <= new_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign txwbcnt_rdreq = wb_rd && !reset;
  assign txdata_rdreq  = data_rd;
  assign frame_err     = err && !reset;
  assign test          = 1'b0;

  assign mac_tx_valid  = (cnt_q != 2'd0);
  assign mac_tx_data   = mac_tx_valid ? head_q.data : '0;
  assign mac_tx_sop    = mac_tx_valid && head_q.sop;
  assign mac_tx_eop    = mac_tx_valid && head_q.eop;
  assign mac_tx_mod    = mac_tx_valid ? head_q.mod : 3'd0;

`ifdef FIB2MAC_STATS_EN
  logic [BCNT_WIDTH-1:0] bcnt_q;

  // Frame byte count kept for the byte statistic at eop acceptance.
  always_ff @(posedge clk) begin
    if (reset)         bcnt_q <= '0;
    else if (len_load) bcnt_q <= rd_txwbcnt_fifo;
  end

  // Delivered-frame statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stat_frames <= '0;
      stat_bytes  <= '0;
    end else if (pop && head_q.eop) begin
      stat_frames <= stat_frames + 32'd1;
      stat_bytes  <= stat_bytes + 32'(bcnt_q);
    end
  end
`endif

endmodule
